mem_arbiter: RTL and testbench

- Shares one single-port memory between the instruction-fetch requester (PC/inst_mem side) and the data requester (EX/DataMem side).
- This is the step from the single-cycle core towards a multicycle core with a unified memory.
- Serialises requests with a req/gnt/rvalid handshake, a fixed-latency memory model and fixed data-over-fetch priority.
- Exposes a busy flag so the core controller can stall the PC.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port, fixed-latency memory.
// Define ARB_RR_EN to give contended grants to the requester not served last.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          owner_q;  // 1: data requester owns the current access
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic any_req;
  logic sel_data;
  logic accept;
  logic in_access;
  logic in_resp;

  assign any_req = if_req | d_req;

`ifdef ARB_RR_EN
  assign sel_data = d_req & (~if_req | ~owner_q);
`else
  assign sel_data = d_req;
`endif

  // Gated by rst so no grant can leak out while reset is held.
  assign accept = rst & (state_q == IDLE) & any_req;
  assign d_gnt  = accept & sel_data;
  assign if_gnt = accept & ~sel_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= sel_data;
            we_q    <= sel_data & d_we;
            addr_q  <= sel_data ? d_addr : if_addr;
            wdata_q <= sel_data ? d_wdata : '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q   <= CNT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign mem_en    = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign if_rvalid = in_resp & ~owner_q;
  assign d_rvalid  = in_resp & owner_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: lane 0 uses MEM_LAT=1, lane 1 uses MEM_LAT=3.
// A cycle-arithmetic transaction model predicts every output on every falling edge.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req    [NL];
  logic [31:0] if_addr   [NL];
  logic        d_req     [NL];
  logic        d_we      [NL];
  logic [31:0] d_addr    [NL];
  logic [31:0] d_wdata   [NL];
  logic [31:0] mem_rdata [NL];
  logic        if_gnt    [NL];
  logic        if_rvalid [NL];
  logic        d_gnt     [NL];
  logic        d_rvalid  [NL];
  logic        mem_en    [NL];
  logic        mem_we    [NL];
  logic        busy      [NL];
  logic [31:0] if_rdata  [NL];
  logic [31:0] d_rdata   [NL];
  logic [31:0] mem_addr  [NL];
  logic [31:0] mem_wdata [NL];

  // memory model state
  int          cyc = 0;
  int          en_cyc  [NL] = '{-100, -100};
  logic [31:0] en_addr [NL] = '{32'h0, 32'h0};
  logic [31:0] ram     [NL][64];

  // transaction model state
  logic        m_act  [NL] = '{1'b0, 1'b0};
  logic        m_own  [NL] = '{1'b0, 1'b0};
  logic        m_we   [NL] = '{1'b0, 1'b0};
  logic        m_last [NL] = '{1'b0, 1'b0};
  int          m_t0   [NL] = '{0, 0};
  logic [31:0] m_addr [NL] = '{32'h0, 32'h0};
  logic [31:0] m_wdat [NL] = '{32'h0, 32'h0};
  logic [31:0] m_rdat [NL] = '{32'h0, 32'h0};
  logic        wd_t;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int LAT = (gi == 0) ? 1 : 3;
    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[gi]),
      .if_addr   (if_addr[gi]),
      .if_gnt    (if_gnt[gi]),
      .if_rvalid (if_rvalid[gi]),
      .if_rdata  (if_rdata[gi]),
      .d_req     (d_req[gi]),
      .d_we      (d_we[gi]),
      .d_addr    (d_addr[gi]),
      .d_wdata   (d_wdata[gi]),
      .d_gnt     (d_gnt[gi]),
      .d_rvalid  (d_rvalid[gi]),
      .d_rdata   (d_rdata[gi]),
      .mem_en    (mem_en[gi]),
      .mem_we    (mem_we[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_wdata (mem_wdata[gi]),
      .mem_rdata (mem_rdata[gi]),
      .busy      (busy[gi])
    );
    // Data is only valid exactly LAT cycles after the strobe; junk otherwise.
    assign mem_rdata[gi] = (cyc == en_cyc[gi] + LAT) ? ram[gi][en_addr[gi][7:2]]
                                                     : (32'hBAD0_0000 | {16'h0, cyc[15:0]});
  end

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic win_data(input int l);
`ifdef ARB_RR_EN
    if (d_req[l] && if_req[l]) return !m_last[l];
`endif
    return d_req[l];
  endfunction

  task automatic check(input int l, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %h expected %h (cycle %0d, t=%0t)", l, nm, got, exp, cyc, $time);
    end
  endtask

  // Memory writes and model advance, all at the rising edge.
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (mem_en[l]) begin
        en_cyc[l]  <= cyc;
        en_addr[l] <= mem_addr[l];
        if (mem_we[l]) ram[l][mem_addr[l][7:2]] <= mem_wdata[l];
      end
      if (!rst) begin
        m_act[l]  <= 1'b0;
        m_rdat[l] <= '0;
        m_last[l] <= 1'b0;
      end else if (!m_act[l]) begin
        if (if_req[l] || d_req[l]) begin
          wd_t       = win_data(l);
          m_act[l]  <= 1'b1;
          m_t0[l]   <= cyc;
          m_own[l]  <= wd_t;
          m_last[l] <= wd_t;
          m_we[l]   <= wd_t && d_we[l];
          m_addr[l] <= wd_t ? d_addr[l] : if_addr[l];
          m_wdat[l] <= wd_t ? d_wdata[l] : 32'h0;
        end
      end else begin
        if (cyc == m_t0[l] + 1 + lat(l) && !m_we[l]) m_rdat[l] <= ram[l][m_addr[l][7:2]];
        if (cyc == m_t0[l] + 2 + lat(l)) m_act[l] <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int   ph;
    logic wd, e_men, e_rv, idle;
    for (int l = 0; l < NL; l++) begin
      ph    = cyc - m_t0[l];
      idle  = !m_act[l];
      wd    = win_data(l);
      e_men = rst && m_act[l] && (ph == 1);
      e_rv  = rst && m_act[l] && (ph == lat(l) + 2);
      check(l, "d_gnt",     d_gnt[l],     rst && idle && d_req[l] && wd);
      check(l, "if_gnt",    if_gnt[l],    rst && idle && if_req[l] && !wd);
      check(l, "mem_en",    mem_en[l],    e_men);
      check(l, "mem_we",    mem_we[l],    e_men && m_we[l]);
      check(l, "mem_addr",  mem_addr[l],  e_men ? m_addr[l] : 32'h0);
      check(l, "mem_wdata", mem_wdata[l], e_men ? m_wdat[l] : 32'h0);
      check(l, "if_rvalid", if_rvalid[l], e_rv && !m_own[l]);
      check(l, "d_rvalid",  d_rvalid[l],  e_rv && m_own[l]);
      check(l, "busy",      busy[l],      rst && m_act[l]);
      check(l, "if_rdata",  if_rdata[l],  rst ? m_rdat[l] : 32'h0);
      check(l, "d_rdata",   d_rdata[l],   rst ? m_rdat[l] : 32'h0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; if_addr[l] = '0;
      d_req[l]  = 1'b0; d_we[l]    = 1'b0;
      d_addr[l] = '0;   d_wdata[l] = '0;
    end
  endtask

  logic gseq [3];
  int   ng;

  initial begin
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 64; i++)
        ram[l][i] = 32'hC0DE_0000 + (l << 12) + i;
    ram[0][4]  = 32'h0050_0093;
    ram[1][32] = 32'h1234_5678;
    rst = 1'b0;
    clear_inputs();

    // reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      step();
      for (int l = 0; l < NL; l++) begin
        if_req[l]  = 1'($urandom_range(0, 1));
        d_req[l]   = 1'($urandom_range(0, 1));
        d_we[l]    = 1'($urandom_range(0, 1));
        if_addr[l] = $urandom();
        d_addr[l]  = $urandom();
        d_wdata[l] = $urandom();
      end
      @(negedge clk);
      check(0, "rst_busy", busy[0], 0);
      check(0, "rst_gnt", {31'h0, d_gnt[0] | if_gnt[0]}, 0);
    end
    step();
    clear_inputs();
    step();
    rst = 1'b1;
    @(negedge clk);
    check(0, "rel_gnt", {31'h0, d_gnt[0] | if_gnt[0]}, 0);
    check(0, "rel_busy", busy[0], 0);

    // fetch read, latency 1
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    @(negedge clk);
    check(0, "t2_if_gnt", if_gnt[0], 1);
    step();
    if_req[0] = 1'b0; if_addr[0] = 32'hFFFF_FF00;
    @(negedge clk);
    check(0, "t2_mem_en", mem_en[0], 1);
    check(0, "t2_mem_we", mem_we[0], 0);
    check(0, "t2_mem_addr", mem_addr[0], 32'h10);
    step(2);
    @(negedge clk);
    check(0, "t2_if_rvalid", if_rvalid[0], 1);
    check(0, "t2_if_rdata", if_rdata[0], 32'h0050_0093);
    check(0, "t2_d_rvalid", d_rvalid[0], 0);
    step();

    // data write
    step();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check(0, "t3_d_gnt", d_gnt[0], 1);
    step();
    d_req[0] = 1'b0; d_we[0] = 1'b0; d_addr[0] = 32'h0; d_wdata[0] = 32'h0;
    @(negedge clk);
    check(0, "t3_mem_we", mem_we[0], 1);
    check(0, "t3_mem_addr", mem_addr[0], 32'h40);
    check(0, "t3_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    step(2);
    @(negedge clk);
    check(0, "t3_d_rvalid", d_rvalid[0], 1);
    check(0, "t3_rdata_kept", d_rdata[0], 32'h0050_0093);
    step();

    // reset during WAIT, held fetch re-granted afterwards
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h24;
    @(negedge clk);
    check(0, "t6_if_gnt", if_gnt[0], 1);
    step();
    if_req[0] = 1'b0;
    step();
    #2;
    rst = 1'b0;
    if_req[0] = 1'b1;
    #1;
    check(0, "t6_rst_busy", busy[0], 0);
    check(0, "t6_rst_rvalid", if_rvalid[0], 0);
    check(0, "t6_rst_gnt", if_gnt[0], 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check(0, "t6_regrant", if_gnt[0], 1);
    step();
    if_req[0] = 1'b0;
    step(2);
    @(negedge clk);
    check(0, "t6_if_rvalid", if_rvalid[0], 1);
    check(0, "t6_if_rdata", if_rdata[0], 32'hC0DE_0009);
    step();

    // contention: data first, fetch at the next IDLE
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h30;
    @(negedge clk);
    check(0, "t4_d_gnt", d_gnt[0], 1);
    check(0, "t4_if_gnt0", if_gnt[0], 0);
    step();
    d_req[0] = 1'b0;
    @(negedge clk);
    check(0, "t4_busy_t1", busy[0], 1);
    step(2);
    @(negedge clk);
    check(0, "t4_d_rvalid", d_rvalid[0], 1);
    check(0, "t4_d_rdata", d_rdata[0], 32'hC0DE_000C);
    step();
    @(negedge clk);
    check(0, "t4_if_gnt", if_gnt[0], 1);
    check(0, "t4_busy_t4", busy[0], 0);
    step();
    if_req[0] = 1'b0;
    step(2);
    @(negedge clk);
    check(0, "t4_if_rvalid", if_rvalid[0], 1);
    check(0, "t4_if_rdata", if_rdata[0], 32'hC0DE_0008);
    step();

    // sustained contention: record three grants
    step();
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    ng = 0;
    for (int k = 0; k < 40 && ng < 3; k++) begin
      @(negedge clk);
      if (d_gnt[0] || if_gnt[0]) begin
        gseq[ng] = d_gnt[0];
        ng++;
      end
      step();
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    check(0, "t4_grant_count", ng, 3);
`ifdef ARB_RR_EN
    check(0, "rr_grant0", {31'h0, gseq[0]}, 1);
    check(0, "rr_grant1", {31'h0, gseq[1]}, 0);
    check(0, "rr_grant2", {31'h0, gseq[2]}, 1);
`else
    check(0, "fix_grant0", {31'h0, gseq[0]}, 1);
    check(0, "fix_grant1", {31'h0, gseq[1]}, 1);
    check(0, "fix_grant2", {31'h0, gseq[2]}, 1);
`endif
    step(6);

    // lane 1: latency 3 data read
    step();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h80;
    @(negedge clk);
    check(1, "t5_d_gnt", d_gnt[1], 1);
    step();
    d_req[1] = 1'b0; d_addr[1] = 32'h0;
    @(negedge clk);
    check(1, "t5_mem_en_t1", mem_en[1], 1);
    check(1, "t5_mem_addr", mem_addr[1], 32'h80);
    step();
    @(negedge clk);
    check(1, "t5_mem_en_t2", mem_en[1], 0);
    step(2);
    @(negedge clk);
    check(1, "t5_d_rvalid_t4", d_rvalid[1], 0);
    step();
    @(negedge clk);
    check(1, "t5_d_rvalid", d_rvalid[1], 1);
    check(1, "t5_d_rdata", d_rdata[1], 32'h1234_5678);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
